// File: rtl/ppm_ctrl.sv
// rtl/ppm_ctrl.sv - requantisation sequencer driving one post_processing pipeline

// Three-stage requantiser: operand register, product register, saturated result register
module post_processing #(
  parameter int DATA_WIDTH  = 8,
  parameter int PSUM_WIDTH  = 32,
  parameter int ALPHA_WIDTH = 8,
  parameter int BETA_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ALPHA_WIDTH-1:0] alpha,
  input  logic [BETA_WIDTH-1:0]  beta,
  input  logic                   if_relu,
  input  logic [PSUM_WIDTH-1:0]  ip,
  output logic [DATA_WIDTH-1:0]  out
);
  localparam int PW = PSUM_WIDTH + ALPHA_WIDTH + 1;
  localparam logic signed [PW-1:0] UMAX = PW'((64'd1 << DATA_WIDTH) - 64'd1);
  localparam logic signed [PW-1:0] SMAX = PW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);

  logic [ALPHA_WIDTH-1:0] alpha_r;
  logic [BETA_WIDTH-1:0]  beta_r, beta_p;
  logic signed [PW-1:0]   prod, rnd, sh;
  logic [DATA_WIDTH-1:0]  sat;

  // Round-half-up, arithmetic shift, then clip to the unsigned or signed byte range
  always_comb begin
    rnd = (beta_p == '0) ? '0 : (PW'(1) <<< (beta_p - BETA_WIDTH'(1)));
    sh  = (prod + rnd) >>> beta_p;
    sat = sh[DATA_WIDTH-1:0];
    if (if_relu) begin
      if (sh < 0)         sat = '0;
      else if (sh > UMAX) sat = '1;
    end else begin
      if (sh > SMAX)      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (sh < SMIN) sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // Scale operands lead the product by one cycle; beta travels with the product
  always_ff @(posedge clk) begin
    if (rst) begin
      alpha_r <= '0;
      beta_r  <= '0;
      beta_p  <= '0;
      prod    <= '0;
      out     <= '0;
    end else begin
      alpha_r <= alpha;
      beta_r  <= beta;
      prod    <= PW'($signed(ip)) * PW'($signed({1'b0, alpha_r}));
      beta_p  <= beta_r;
      out     <= sat;
    end
  end
endmodule

module ppm_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PSUM_WIDTH  = 32,
  parameter int ALPHA_WIDTH = 8,
  parameter int BETA_WIDTH  = 4,
  parameter int CH_MAX      = 16,
  parameter int CH_BITS     = 4,
  parameter int PIX_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [CH_BITS-1:0]     cfg_addr,
  input  logic [ALPHA_WIDTH-1:0] cfg_alpha,
  input  logic [BETA_WIDTH-1:0]  cfg_beta,
  input  logic                   start,
  input  logic                   job_relu,
  input  logic [CH_BITS-1:0]     job_nch,
  input  logic [PIX_BITS-1:0]    job_npix,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [PSUM_WIDTH-1:0]  psum_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ALPHA_WIDTH-1:0] tbl_alpha [CH_MAX];
  logic [BETA_WIDTH-1:0]  tbl_beta  [CH_MAX];
  logic                   relu_q;
  logic [CH_BITS-1:0]     nch_q, ch_cnt;
  logic [PIX_BITS-1:0]    npix_q, pix_cnt;
  logic [ALPHA_WIDTH-1:0] ppm_alpha;
  logic [BETA_WIDTH-1:0]  ppm_beta;
  logic [PSUM_WIDTH-1:0]  ppm_ip;
  logic [DATA_WIDTH-1:0]  ppm_out;
  logic [2:0]             vpipe, inflight, fifo_cnt;
  logic [DATA_WIDTH-1:0]  fifo_mem [4];
  logic [1:0]             wr_ptr, rd_ptr;
  logic                   hs, push, pop, credit_ok, last_pix, last_ch;

  assign inflight   = {2'b0, vpipe[0]} + {2'b0, vpipe[1]} + {2'b0, vpipe[2]};
  assign credit_ok  = (fifo_cnt + inflight) < 3'd4;
  assign psum_ready = (state == S_RUN) && credit_ok;
  assign hs         = psum_valid && psum_ready;
  assign push       = vpipe[2];
  assign out_valid  = (fifo_cnt != 3'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy       = (state != S_IDLE);
  assign last_pix   = (pix_cnt == npix_q);
  assign last_ch    = (ch_cnt == nch_q);

  post_processing #(
    .DATA_WIDTH (DATA_WIDTH),
    .PSUM_WIDTH (PSUM_WIDTH),
    .ALPHA_WIDTH(ALPHA_WIDTH),
    .BETA_WIDTH (BETA_WIDTH)
  ) u_ppm (
    .clk    (clk),
    .rst    (rst),
    .alpha  (ppm_alpha),
    .beta   (ppm_beta),
    .if_relu(relu_q),
    .ip     (ppm_ip),
    .out    (ppm_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; DRAIN exits as soon as the final pop is happening so done follows it by one cycle
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (hs && last_pix) state_nxt = last_ch ? S_DRAIN : S_LOAD;
      S_DRAIN: if (inflight == 3'd0 && (fifo_cnt == 3'd0 || (fifo_cnt == 3'd1 && pop)))
                 state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Channel table, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_MAX; i++) begin
        tbl_alpha[i] <= '0;
        tbl_beta[i]  <= '0;
      end
    end else if (cfg_we && state == S_IDLE) begin
      tbl_alpha[cfg_addr] <= cfg_alpha;
      tbl_beta[cfg_addr]  <= cfg_beta;
    end
  end

  // Job latch, channel/pixel counters and per-channel scale operands
  always_ff @(posedge clk) begin
    if (rst) begin
      relu_q    <= 1'b0;
      nch_q     <= '0;
      npix_q    <= '0;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      ppm_alpha <= '0;
      ppm_beta  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        relu_q  <= job_relu;
        nch_q   <= job_nch;
        npix_q  <= job_npix;
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end
      if (state == S_LOAD) begin
        ppm_alpha <= tbl_alpha[ch_cnt];
        ppm_beta  <= tbl_beta[ch_cnt];
      end
      if (state == S_RUN && hs) begin
        if (last_pix) begin
          pix_cnt <= '0;
          if (!last_ch) ch_cnt <= ch_cnt + CH_BITS'(1);
        end else begin
          pix_cnt <= pix_cnt + PIX_BITS'(1);
        end
      end
    end
  end

  // Operand register into the PPM and the in-flight valid pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      ppm_ip <= '0;
      vpipe  <= '0;
    end else begin
      vpipe <= {vpipe[1:0], hs};
      if (hs) ppm_ip <= psum_data;
    end
  end

  // Four-entry fall-through output FIFO; credit keeps pushes from ever overflowing it
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ppm_out;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_ppm_ctrl.sv
// tb/tb_ppm_ctrl.sv - randomized self-checking bench for ppm_ctrl
module tb_ppm_ctrl;
  logic        clk, rst, cfg_we, start, job_relu, psum_valid, psum_ready;
  logic        out_valid, out_ready, busy, done;
  logic [3:0]  cfg_addr, cfg_beta, job_nch;
  logic [7:0]  cfg_alpha, out_data;
  logic [15:0] job_npix;
  logic [31:0] psum_data;

  int n_vec = 0, n_miss = 0;
  int cyc = 0, acc_cnt = 0, acc_at_hold = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int sh_alpha [16];
  int sh_beta  [16];
  int psum_q [$];
  int hs_cyc_q [$];
  int pop_cyc_q [$];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  ppm_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_alpha(cfg_alpha),
    .cfg_beta(cfg_beta), .start(start), .job_relu(job_relu), .job_nch(job_nch),
    .job_npix(job_npix), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        pop_cyc_q.push_back(cyc);
      end
      if (psum_valid && psum_ready) begin
        acc_cnt++;
        hs_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [7:0] ref_byte(int psum, int a, int b, bit relu);
    longint v;
    v = longint'(psum) * longint'(a);
    if (b > 0) v = (v + (longint'(1) << (b - 1))) >>> b;
    if (relu) begin
      if (v < 0) v = 0;
      if (v > 255) v = 255;
    end else begin
      if (v < -128) v = -128;
      if (v > 127) v = 127;
    end
    return 8'(v);
  endfunction

  function automatic int rnd_psum();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  task automatic build_exp(input int npix, input bit relu);
    exp_q.delete();
    foreach (psum_q[i]) begin
      int ch;
      ch = i / (npix + 1);
      exp_q.push_back(ref_byte(psum_q[i], sh_alpha[ch], sh_beta[ch], relu));
    end
  endtask

  task automatic write_cfg(input int a, input int al, input int be);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = 4'(a); cfg_alpha = 8'(al); cfg_beta = 4'(be);
    @(posedge clk); #1;
    cfg_we = 0;
    sh_alpha[a] = al;
    sh_beta[a]  = be;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 16; i++) begin
      sh_alpha[i] = 0;
      sh_beta[i]  = 0;
    end
  endtask

  task automatic drive_job(input int nch, input int npix, input bit relu, input int vpct,
                           input int rpct, input int hold, input int stray, output bit finished);
    int idx, n;
    bit hs;
    n = psum_q.size();
    finished = 0;
    got_q.delete(); pop_cyc_q.delete(); hs_cyc_q.delete();
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1; job_nch = 4'(nch); job_npix = 16'(npix); job_relu = relu;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 0;
    idx = 0;
    for (int c = 0; c < 4000 && !finished; c++) begin
      if (c == hold) acc_at_hold = acc_cnt;
      psum_valid = (idx < n) && ($urandom_range(0, 99) < vpct);
      psum_data  = (idx < n) ? psum_q[idx] : 32'd0;
      out_ready  = (c >= hold) && ($urandom_range(0, 99) < rpct);
      cfg_we     = (c == stray);
      start      = (c == stray);
      cfg_addr   = 4'd1; cfg_alpha = 8'hee; cfg_beta = 4'h7;
      job_nch    = (c == stray) ? 4'd3 : 4'(nch);
      job_relu   = (c == stray) ? ~relu : relu;
      @(negedge clk);
      hs = psum_valid && psum_ready;
      if (done) finished = 1;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    psum_valid = 0; out_ready = 1; cfg_we = 0; start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (psum_ready !== 1'b0) begin n_miss++; $display("FAIL reset_psum_ready got %b want 0", psum_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_miss++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done got %b want 0", done); end
    @(posedge clk); #1;
    rst = 0;
    clear_shadow();
    begin
      bit fin;
      psum_q = '{123, -45};
      build_exp(1, 0);
      drive_job(0, 1, 0, 100, 100, 0, -1, fin);
      n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL reset_job_timeout got %b want 1", fin); end
      n_vec++; if (got_q.size() != exp_q.size()) begin n_miss++; $display("FAIL reset_job_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL reset_job_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_single();
    bit fin;
    write_cfg(0, 3, 2);
    psum_q = '{100, 4, -5, 400};
    exp_q  = '{8'd75, 8'd3, 8'd0, 8'd255};
    @(posedge clk); #1;
    drive_job(0, 3, 1, 100, 100, 0, -1, fin);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL single_timeout got %b want 1", fin); end
    n_vec++; if (got_q.size() != 4) begin n_miss++; $display("FAIL single_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL single_byte%0d got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 4 && hs_cyc_q.size() == 4) begin
      n_vec++; if (hs_cyc_q[0] - start_cyc != 2) begin n_miss++; $display("FAIL single_start_latency got %0d want 2", hs_cyc_q[0] - start_cyc); end
      n_vec++; if (pop_cyc_q[0] - hs_cyc_q[0] != 4) begin n_miss++; $display("FAIL single_pipe_latency got %0d want 4", pop_cyc_q[0] - hs_cyc_q[0]); end
      n_vec++; if (done_cyc - pop_cyc_q[3] != 1) begin n_miss++; $display("FAIL single_done_delay got %0d want 1", done_cyc - pop_cyc_q[3]); end
    end else begin
      n_vec++; n_miss++; $display("FAIL single_handshakes got %0d want 4", hs_cyc_q.size());
    end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL single_busy_after got %b want 0", busy); end
  endtask

  task automatic test_clip();
    bit fin;
    write_cfg(0, 1, 0);
    psum_q = '{200, -300, 5};
    exp_q  = '{8'd127, 8'h80, 8'd5};
    drive_job(0, 2, 0, 100, 100, 0, -1, fin);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL clip_timeout got %b want 1", fin); end
    n_vec++; if (got_q.size() != 3) begin n_miss++; $display("FAIL clip_count got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL clip_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_two_ch();
    bit fin;
    write_cfg(0, 2, 1);
    write_cfg(1, 1, 0);
    psum_q = '{10, 11, 7, 8};
    exp_q  = '{8'd10, 8'd11, 8'd7, 8'd8};
    drive_job(1, 1, 0, 100, 100, 0, -1, fin);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL two_ch_timeout got %b want 1", fin); end
    n_vec++; if (got_q.size() != 4) begin n_miss++; $display("FAIL two_ch_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL two_ch_byte%0d got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    if (hs_cyc_q.size() == 4) begin
      n_vec++; if (hs_cyc_q[1] - hs_cyc_q[0] != 1) begin n_miss++; $display("FAIL two_ch_gap01 got %0d want 1", hs_cyc_q[1] - hs_cyc_q[0]); end
      n_vec++; if (hs_cyc_q[2] - hs_cyc_q[1] != 2) begin n_miss++; $display("FAIL two_ch_bubble got %0d want 2", hs_cyc_q[2] - hs_cyc_q[1]); end
      n_vec++; if (hs_cyc_q[3] - hs_cyc_q[2] != 1) begin n_miss++; $display("FAIL two_ch_gap23 got %0d want 1", hs_cyc_q[3] - hs_cyc_q[2]); end
    end else begin
      n_vec++; n_miss++; $display("FAIL two_ch_handshakes got %0d want 4", hs_cyc_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit fin;
    write_cfg(0, 5, 1);
    psum_q.delete();
    for (int i = 0; i < 8; i++) psum_q.push_back(rnd_psum());
    build_exp(7, 0);
    drive_job(0, 7, 0, 100, 100, 20, -1, fin);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL bp_timeout got %b want 1", fin); end
    n_vec++; if (acc_at_hold != 4) begin n_miss++; $display("FAIL bp_accepts_while_stalled got %0d want 4", acc_at_hold); end
    n_vec++; if (got_q.size() != 8) begin n_miss++; $display("FAIL bp_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL bp_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit fin;
    int base_done, c;
    write_cfg(0, 3, 2);
    got_q.delete();
    acc_cnt = 0;
    base_done = done_cnt;
    @(posedge clk); #1;
    start = 1; job_nch = 4'd0; job_npix = 16'd7; job_relu = 1;
    @(posedge clk); #1;
    start = 0; psum_valid = 1; psum_data = 32'd100; out_ready = 1;
    for (c = 0; c < 50 && acc_cnt < 2; c++) begin
      @(negedge clk); #1;
    end
    n_vec++; if (acc_cnt != 2) begin n_miss++; $display("FAIL rstmid_accepts got %0d want 2", acc_cnt); end
    @(posedge clk); #1;
    rst = 1; psum_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    n_vec++; if (psum_ready !== 1'b0) begin n_miss++; $display("FAIL rstmid_psum_ready got %b want 0", psum_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_miss++; $display("FAIL rstmid_out_data got %h want 00", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (got_q.size() != 0) begin n_miss++; $display("FAIL rstmid_ghost_bytes got %0d want 0", got_q.size()); end
    n_vec++; if (done_cnt != base_done) begin n_miss++; $display("FAIL rstmid_done_pulses got %0d want 0", done_cnt - base_done); end
    clear_shadow();
    write_cfg(0, 7, 3);
    write_cfg(1, 200, 9);
    psum_q.delete();
    for (int i = 0; i < 6; i++) psum_q.push_back(rnd_psum());
    build_exp(2, 1);
    drive_job(1, 2, 1, 80, 80, 0, -1, fin);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL rstmid_after_timeout got %b want 1", fin); end
    n_vec++; if (got_q.size() != 6) begin n_miss++; $display("FAIL rstmid_after_count got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL rstmid_after_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stray();
    bit fin;
    write_cfg(0, 3, 1);
    write_cfg(1, 2, 0);
    psum_q = '{40, -7, 13, 60, -2, 90};
    build_exp(2, 0);
    drive_job(1, 2, 0, 100, 100, 0, 2, fin);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL stray_timeout got %b want 1", fin); end
    n_vec++; if (got_q.size() != 6) begin n_miss++; $display("FAIL stray_count got %0d want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL stray_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bit fin, relu;
      int nch, npix;
      nch  = $urandom_range(0, 3);
      npix = $urandom_range(0, 4);
      relu = 1'($urandom_range(0, 1));
      for (int ch = 0; ch <= nch; ch++) write_cfg(ch, $urandom_range(0, 255), $urandom_range(0, 15));
      psum_q.delete();
      for (int i = 0; i < (nch + 1) * (npix + 1); i++) psum_q.push_back(rnd_psum());
      build_exp(npix, relu);
      drive_job(nch, npix, relu, 70, 60, 0, -1, fin);
      n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL rand%0d_timeout got %b want 1", it, fin); end
      n_vec++; if (got_q.size() != exp_q.size()) begin n_miss++; $display("FAIL rand%0d_count got %0d want %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++; if (got_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL rand%0d_byte%0d got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    rst = 1; cfg_we = 0; cfg_addr = 0; cfg_alpha = 0; cfg_beta = 0; start = 0;
    job_relu = 0; job_nch = 0; job_npix = 0; psum_valid = 0; psum_data = 0; out_ready = 1;
    clear_shadow();
    test_reset();
    test_single();
    test_clip();
    test_two_ch();
    test_backpressure();
    test_reset_mid();
    test_stray();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
